// File: rtl/calc_pkg.sv
// Shared calculator types and keypad helpers.
package calc_pkg;

    localparam int KP_ROWS    = 4;
    localparam int KP_COLS    = 4;
    localparam int KEY_CODE_W = 4;
    localparam int KP_KEYS    = KP_ROWS * KP_COLS;

    typedef logic [KEY_CODE_W-1:0] key_code_t;
    typedef logic [KP_KEYS-1:0]    key_mask_t;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        BLOCKED
    } kp_state_t;

    // Number of keys down in a matrix mask.
    function automatic int unsigned count_keys(input key_mask_t m);
        int unsigned n;
        n = 0;
        for (int i = 0; i < KP_KEYS; i++) begin
            if (m[i]) n++;
        end
        return n;
    endfunction

    // Code of the lowest set key; only meaningful when exactly one bit is set.
    function automatic key_code_t lowest_key(input key_mask_t m);
        key_code_t k;
        k = '0;
        for (int i = KP_KEYS - 1; i >= 0; i--) begin
            if (m[i]) k = key_code_t'(i);
        end
        return k;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Column slot timer: holds each column for SCAN_DIV cycles and flags the
// last cycle of every slot as the row sampling point.
module scan_timer #(
    parameter int SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    output logic       sample_o,
    output logic [1:0] col_idx_o
);

    localparam int               CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] slot_q, slot_d;
    logic [1:0]       col_q, col_d;
    logic             last_slot;

    // Advance the slot counter and step to the next column at slot end.
    always_comb begin
        last_slot = (slot_q == LAST);
        slot_d    = last_slot ? '0 : slot_q + CNT_W'(1);
        col_d     = last_slot ? col_q + 2'd1 : col_q;
    end

    // Slot and column registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
            col_q  <= '0;
        end else begin
            slot_q <= slot_d;
            col_q  <= col_d;
        end
    end

    assign sample_o  = last_slot;
    assign col_idx_o = col_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobing, full-matrix debounce and a
// single-key press reporter that ignores chords until all keys are released.
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KP_ROWS-1:0] row_in,
    output logic [KP_COLS-1:0] col_out,
    output key_code_t          key_code,
    output logic               key_valid,
    output logic               key_held
);

    localparam int               STB_W   = $clog2(DEBOUNCE_SCANS);
    localparam logic [STB_W-1:0] STB_MAX = STB_W'(DEBOUNCE_SCANS - 1);

    logic        sample;
    logic [1:0]  col_idx;

    key_mask_t        snap_q, snap_d;
    key_mask_t        prev_q, prev_d;
    key_mask_t        deb_q, deb_d;
    logic [STB_W-1:0] stable_q, stable_d;
    logic             eos_q, eos_d;
    logic             deb_upd;

    kp_state_t   state_q, state_d;
    key_code_t   code_q, code_d;
    logic        valid_q, valid_d;
    logic        held_q, held_d;
    int unsigned nkeys;

    scan_timer #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan_timer (
        .clk       (clk),
        .rst       (rst),
        .sample_o  (sample),
        .col_idx_o (col_idx)
    );

    // Active-low one-hot strobe decoded from the registered column index.
    assign col_out = ~(KP_COLS'(1) << col_idx);

    // Snapshot capture at each sample point and debounce at end of scan.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        snap_d   = snap_q;
        prev_d   = prev_q;
        deb_d    = deb_q;
        stable_d = stable_q;
        deb_upd  = 1'b0;
        eos_d    = sample && (col_idx == 2'(KP_COLS - 1));

        if (sample) begin
            for (int r = 0; r < KP_ROWS; r++) begin
                snap_d[r * KP_COLS + int'(col_idx)] = ~row_in[r];
            end
        end

        // Column 0 of the next scan is not sampled yet, so snap_q is complete here.
        if (eos_q) begin
            prev_d = snap_q;
            if (snap_q == prev_q) begin
                stable_d = (stable_q == STB_MAX) ? STB_MAX : stable_q + STB_W'(1);
            end else begin
                stable_d = '0;
            end
            if (stable_d == STB_MAX) begin
                deb_d   = snap_q;
                deb_upd = 1'b1;
            end
        end
    end

    // Scan datapath registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            snap_q   <= '0;
            prev_q   <= '0;
            deb_q    <= '0;
            stable_q <= '0;
            eos_q    <= 1'b0;
        end else begin
            snap_q   <= snap_d;
            prev_q   <= prev_d;
            deb_q    <= deb_d;
            stable_q <= stable_d;
            eos_q    <= eos_d;
        end
    end

    // Press reporter, reacting in the same cycle the debounced state is written.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = (deb_d != '0);
        nkeys   = count_keys(deb_d);

        if (deb_upd) begin
            case (state_q)
                IDLE: begin
                    if (nkeys == 1) begin
                        code_d  = lowest_key(deb_d);
                        valid_d = 1'b1;
                        state_d = PRESSED;
                    end else if (nkeys >= 2) begin
                        state_d = BLOCKED;
                    end
                end
                PRESSED, BLOCKED: begin
                    if (deb_d == '0) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Reporter state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            code_q  <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a behavioural keypad model drives the
// rows from the column strobes, and a per-scan reference model predicts
// press reports and held state.
module tb_keypad_scanner;
    import calc_pkg::*;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int SCAN_CYC = 4 * SCAN_DIV;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    logic [3:0] row_in;
    logic [3:0] col_out;
    key_code_t key_code;
    logic      key_valid;
    logic      key_held;

    logic [15:0] keys = '0;
    int          cyc  = 0;
    int          n_pass   = 0;
    int          n_checks = 0;

    typedef struct {
        int         at;
        logic       held;
        logic [3:0] code;
    } exp_t;

    exp_t pulse_q[$];
    exp_t held_q[$];

    logic [15:0] m_prev, m_deb;
    int          m_cnt, m_scan;
    bit          m_armed;
    logic [3:0]  m_code;

    logic [3:0] exp_col;
    logic       exp_v;
    exp_t       e_p, e_h;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Keypad: a row is pulled low when a pressed key in it sits on the strobed column.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            row_in[r] = ~|(keys[r*4 +: 4] & ~col_out);
        end
    end

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        m_prev  = '0;
        m_deb   = '0;
        m_cnt   = 0;
        m_scan  = 0;
        m_armed = 1'b1;
        m_code  = '0;
    endtask

    // One full scan seen with a constant key mask.
    task automatic model_scan(input logic [15:0] mask);
        exp_t e;
        if (mask == m_prev) m_cnt = (m_cnt < DEB - 1) ? m_cnt + 1 : DEB - 1;
        else                m_cnt = 0;
        m_prev = mask;
        e.at = SCAN_CYC * (m_scan + 1) + 1;
        if (m_cnt == DEB - 1) begin
            m_deb = mask;
            if (mask == 0) begin
                m_armed = 1'b1;
            end else if (m_armed) begin
                m_armed = 1'b0;
                if ($countones(mask) == 1) begin
                    m_code = 4'($clog2(mask));
                    e.held = 1'b1;
                    e.code = m_code;
                    pulse_q.push_back(e);
                end
            end
        end
        e.held = (m_deb != 0);
        e.code = m_code;
        held_q.push_back(e);
        m_scan++;
    endtask

    task automatic run_scan(input logic [15:0] mask);
        keys = mask;
        model_scan(mask);
        repeat (SCAN_CYC) @(posedge clk);
        #1;
    endtask

    task automatic run_scans(input logic [15:0] mask, input int n);
        for (int i = 0; i < n; i++) run_scan(mask);
    endtask

    // Apply one reset edge and check every output right after it.
    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_col_out", col_out, 4'b1110);
        check("rst_key_code", key_code, 4'd0);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_key_held", key_held, 1'b0);
        rst = 1'b0;
        model_reset();
    endtask

    // Monitor: strobe order every cycle, pulses and held state from the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            exp_col = ~(4'b0001 << ((cyc / SCAN_DIV) % 4));
            check("col_out", col_out, exp_col);
            exp_v = 1'b0;
            if (pulse_q.size() > 0 && pulse_q[0].at == cyc) begin
                e_p   = pulse_q.pop_front();
                exp_v = 1'b1;
                check("key_code_on_valid", key_code, e_p.code);
            end
            check("key_valid", key_valid, exp_v);
            if (held_q.size() > 0 && held_q[0].at == cyc) begin
                e_h = held_q.pop_front();
                check("key_held", key_held, e_h.held);
                check("key_code_kept", key_code, e_h.code);
            end
        end
    end

    initial begin
        int         choice, nscan;
        int         k1, k2;
        logic [15:0] m;

        keys = '0;
        repeat (2) @(posedge clk);
        do_reset();

        // Idle scanning: strobe order only, no reports.
        run_scans(16'h0000, 3);

        // Single press at row 2, col 1 (code 9), held well past acceptance.
        run_scans(16'h0200, 5);
        // Release, then press row 0, col 3 (code 3).
        run_scans(16'h0000, 4);
        run_scans(16'h0008, 4);
        run_scans(16'h0000, 4);

        // Bounce on alternate scans, then a steady press of code 5.
        for (int i = 0; i < 6; i++) run_scan((i % 2 == 0) ? 16'h0020 : 16'h0000);
        run_scans(16'h0020, 4);
        run_scans(16'h0000, 4);

        // Chord (1,1)+(3,0), then drop (3,0): no report until full release.
        run_scans(16'h1020, 4);
        run_scans(16'h0020, 4);
        run_scans(16'h0000, 4);
        run_scans(16'h0020, 4);
        run_scans(16'h0000, 4);

        // Reset during column 2 with a key held, then the key is re-reported.
        run_scans(16'h0200, 4);
        keys = 16'h0200;
        repeat (9) @(posedge clk);
        #1;
        do_reset();
        run_scans(16'h0200, 4);
        run_scans(16'h0000, 4);

        // Random masks: idle, single keys and chords held for 1..4 scans.
        for (int it = 0; it < 24; it++) begin
            choice = $urandom_range(0, 3);
            k1     = $urandom_range(0, 15);
            k2     = (k1 + $urandom_range(1, 15)) % 16;
            m      = '0;
            if (choice == 1 || choice == 2) m[k1] = 1'b1;
            if (choice == 3) begin
                m[k1] = 1'b1;
                m[k2] = 1'b1;
            end
            nscan = $urandom_range(1, 4);
            run_scans(m, nscan);
        end
        run_scans(16'h0000, 4);
        repeat (4) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans the calculator's 4x4 matrix keypad and reports debounced key presses to the calculator control logic.
- It is the input-side counterpart of the LED display drivers: it drives active-low column strobes and reads the active-low row returns.
- It emits one key code with a single-cycle valid pulse per press, and reports a held indication while any key is down.

Parameters:
- SCAN_DIV, 100000: clk cycles each column strobe is held (1 ms at 100 MHz); minimum 2.
- DEBOUNCE_SCANS, 4: number of consecutive identical full-matrix scans needed to accept a new key state; minimum 2.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous active-high reset.
- row_in, input, 4: keypad rows, active-low, externally pulled up; already synchronised upstream.
- col_out, output, 4: column strobes, active-low one-hot.
- key_code, output, 4: code of the last accepted key, code = row*4 + col.
- key_valid, output, 1: one-cycle pulse when key_code is newly updated.
- key_held, output, 1: high while the debounced matrix state is non-zero.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous, active-high, on rst sampled at posedge clk.
- Reset values:
  - Outputs: col_out=4'b1110, key_code=0, key_valid=0, key_held=0.
  - Internal: slot counter=0, column index=0, snapshot=0, previous snapshot=0, stable count=0, debounced state=0, FSM=IDLE.
- Reset mid-scan: the partial snapshot is discarded and scanning restarts at column 0.
- Column scan:
  - Column c is active (col_out[c]=0, others 1) for exactly SCAN_DIV cycles.
  - Order is col 0, 1, 2, 3, then wrap to 0. A full scan lasts 4*SCAN_DIV cycles.
- Row sampling:
  - Rows are sampled only in the last cycle of each column slot, to allow settling.
  - Pressed bit for (r,c) = ~row_in[r] at that sample, stored into snapshot bit r*4+c.
- End of scan (the cycle after column 3 is sampled):
  - If snapshot == previous snapshot: stable count increments, saturating at DEBOUNCE_SCANS-1. Otherwise stable count resets to 0.
  - previous snapshot <= snapshot.
  - When the stable count reaches DEBOUNCE_SCANS-1, debounced state <= snapshot. This happens on the DEBOUNCE_SCANS-th identical scan.
- FSM, evaluated on each debounced-state update:
  - IDLE, debounced has exactly one bit set: key_code <= that bit index; key_valid=1 for one cycle; go to PRESSED.
  - IDLE, debounced has two or more bits set: no pulse, key_code unchanged; go to BLOCKED.
  - PRESSED or BLOCKED, debounced == 0: go to IDLE.
  - PRESSED, additional key joins: no new pulse; stay until all keys are released.
  - BLOCKED, reduces to exactly one key: no pulse. A release to all-zero is required before the next report.
- key_held: equals (debounced state != 0) and is registered.
- Latency: key_valid asserts exactly one cycle after the end-of-scan cycle of the DEBOUNCE_SCANS-th identical non-zero scan.
- Bounce handling: any differing scan restarts debouncing. Glitches shorter than one scan that miss the sample points are invisible by design.
- key_code holds its value until the next accepted press. key_valid is never high on two consecutive cycles.

Decomposition:
- Shared package calc_pkg holds:
  - constants KP_ROWS=4, KP_COLS=4, KEY_CODE_W=4;
  - typedef kp_state_t {IDLE, PRESSED, BLOCKED};
  - typedef key_code_t.
- One sub-module, scan_timer: slot counter 0..SCAN_DIV-1, producing a sample strobe in the last cycle of each slot and the 2-bit column index.
- Snapshot, debounce and FSM stay in keypad_scanner.

Test Plan:
- Test parameters for all scenarios: SCAN_DIV=4, DEBOUNCE_SCANS=3.
- Scan order: after rst, col_out follows 1110 (cycles 0-3), 1101 (4-7), 1011 (8-11), 0111 (12-15), then 1110 again. key_valid stays 0 with row_in=1111.
- Single press: hold key (row 2, col 1) by driving row_in[2]=0 only while col_out[1]=0 → exactly one key_valid pulse with key_code=9 after the 3rd identical scan; key_held=1; no further pulse while held.
- Release then repress: release (row_in=1111) → key_held falls after 3 clean scans. Then press (row 0, col 3) → key_valid pulse with key_code=3.
- Bounce: toggle the pressed state on alternate scans for 6 scans, then hold steady → no pulse during the bouncing; one pulse 3 stable scans after the bouncing stops.
- Two keys: press (1,1) and (3,0) simultaneously → key_held=1, key_valid never asserts, key_code stays at its prior value. Release (3,0) only → still no pulse until a full release and a new single press.
- Reset mid-operation: assert rst during column 2 with a key held → next cycle all outputs are at reset values and col_out=1110. After rst deasserts, the held key is reported after 3 full scans.
